tp84_sound_mixer: RTL and testbench
===================================

// Module: tp84_sound_mixer
// PURPOSE
//  Sequential 4-channel audio mixer feeding the tp84 low-pass filter chain.
//  Snapshots the three SN76489 outputs plus the DAC channel once per sample period.
//  Scales each channel by an 8-bit gain and accumulates serially, one channel per clock.
//  Saturates the sum to signed 16 bits and holds it on `out` until the next period.
//  `out` drives the `in` port of the medium/heavy LPF stages, at the same 192 kHz rate.
// PARAMETERS
//  DIV   256   clocks per output sample (49.152 MHz / 256 = 192 kHz); legal range 8..1023
// PORTS
//  clk        in   1   system clock, 49.152 MHz
//  reset      in   1   synchronous reset, active-high
//  in0..in3   in   16  signed channel samples (PSG0, PSG1, PSG2, DAC)
//  gain0..3   in   8   unsigned per-channel gain, Q1.7 (128 = unity, 255 = ~1.99x)
//  mute       in   1   forces result to 0 for the sample being captured
//  out        out  16  signed mixed sample, held between updates
//  out_valid  out  1   one-clock pulse in the cycle `out` takes a new value
//  clip       out  1   valid with out_valid; high if the current `out` was saturated
// BEHAVIOUR
//  Reset values
//   - cnt = 0, state = IDLE, acc = 0.
//   - out = 0, out_valid = 0, clip = 0.
//   - Reset wins over every other event in the same cycle.
//  Period counter
//   - cnt counts 0..DIV-1 and wraps; tick = (cnt == DIV-1).
//   - tick is used only in IDLE; the FSM always returns to IDLE before the next tick.
//  FSM states: IDLE, ACC0, ACC1, ACC2, ACC3, SAT.
//   - IDLE -> ACC0 on tick. On that edge: capture in0..3, gain0..3 and mute into
//     snapshot registers, and clear acc.
//   - ACCn -> next state, unconditionally. Each step does
//     acc += in_n_snap * {1'b0, gain_n_snap}.
//   - SAT -> IDLE.
//   - On the SAT edge:
//       out = mute_snap ? 0 : sat16(acc >>> 7)
//       out_valid = 1 for exactly one cycle
//       clip = (!mute_snap && saturation occurred)
//  Widths and arithmetic
//   - Product is 16x9 signed = 25 bits; acc is 27-bit signed, so there is no
//     internal overflow.
//   - `>>> 7` is an arithmetic shift: truncation toward -inf, no rounding.
//   - sat16 clamps to the range [-32768, 32767].
//  Latency
//   - The capture edge is the edge where tick is high.
//   - `out` updates 5 edges after the capture edge.
//   - From reset release, the first out_valid follows rising edge DIV+5.
//   - Output period is exactly DIV clocks.
//  Boundary conditions
//   - Inputs, gains or mute changing after the capture edge have no effect until
//     the next period.
//   - Reset during ACCx or SAT aborts the computation: out = 0, no valid pulse,
//     and counting restarts from cnt = 0.
//   - Gain 0 on every channel gives out = 0 with clip = 0.
//   - clip keeps its value until the next out_valid.
// TESTING
//  1. Reset held 4 clocks, then released.
//     -> out = 0 and out_valid = 0 throughout.
//     -> First out_valid after edge DIV+5; successive pulses exactly DIV apart.
//  2. Gains all 128; in = 1000, 2000, -500, 0.
//     -> out = 2500, clip = 0.
//     -> Same stimulus with gain3 = 0 and in3 = 32767 -> still 2500.
//  3. Saturation, gains all 255.
//     -> All inputs 32767: out = 32767, clip = 1.
//     -> All inputs -32768: out = -32768, clip = 1.
//  4. Truncation, only channel 0 active with gain0 = 64.
//     -> in0 = 1001: out = 500.
//     -> in0 = -1001: out = -501.
//  5. Snapshot and mute.
//     -> in0 changes from 1000 to 5000 one clock after capture: this sample is
//        1000 x gain0 (5000 appears only in the next period).
//     -> mute high at capture: out = 0, clip = 0, out_valid still pulses.
//  6. Reset mid-operation.
//     -> Reset pulsed 1 clock during ACC2: no out_valid, out = 0.
//     -> Next out_valid exactly DIV+5 edges after release, with the correct sum.

Source files
------------

// File: rtl/tp84_sound_mixer_if.sv
// Channel/gain/mute inputs and mixed-sample outputs of the tp84 sound mixer.
// The source side (master) drives samples and gains; the mixer side (slave) returns the mix.
interface tp84_sound_mixer_if;
  logic signed [15:0] in0;
  logic signed [15:0] in1;
  logic signed [15:0] in2;
  logic signed [15:0] in3;
  logic [7:0]         gain0;
  logic [7:0]         gain1;
  logic [7:0]         gain2;
  logic [7:0]         gain3;
  logic               mute;
  logic signed [15:0] out;
  logic               out_valid;
  logic               clip;

  modport master (
    output in0, in1, in2, in3,
    output gain0, gain1, gain2, gain3,
    output mute,
    input  out, out_valid, clip
  );

  modport slave (
    input  in0, in1, in2, in3,
    input  gain0, gain1, gain2, gain3,
    input  mute,
    output out, out_valid, clip
  );
endinterface

// File: rtl/tp84_sound_mixer.sv
// Sequential 4-channel gain/accumulate mixer: snapshot once per DIV clocks, accumulate
// one channel per clock, saturate to signed 16 bits and hold until the next period.
module tp84_sound_mixer #(
  parameter int DIV = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  tp84_sound_mixer_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    ACC3 = 3'd4,
    SAT  = 3'd5
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(DIV - 1);

  state_t             state_reg;
  logic [9:0]         cnt_reg;
  logic               tick;
  logic               capture;

  logic signed [15:0] in_bus    [4];
  logic [7:0]         gain_bus  [4];
  logic signed [15:0] in_snap   [4];
  logic [7:0]         gain_snap [4];
  logic               mute_snap;

  logic [1:0]         ch_sel;
  logic signed [15:0] in_sel;
  logic signed [8:0]  gain_sel;
  logic signed [24:0] prod;
  logic signed [26:0] acc_reg;
  logic signed [19:0] acc_shift;
  logic               sat_hi;
  logic               sat_lo;
  logic signed [15:0] sat_val;

  logic signed [15:0] out_reg;
  logic               out_valid_reg;
  logic               clip_reg;

  assign tick    = (cnt_reg == CNT_LAST);
  assign capture = (state_reg == IDLE) && tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 10'd1;
    end
  end

  always_comb begin
    in_bus[0]   = bus.in0;
    in_bus[1]   = bus.in1;
    in_bus[2]   = bus.in2;
    in_bus[3]   = bus.in3;
    gain_bus[0] = bus.gain0;
    gain_bus[1] = bus.gain1;
    gain_bus[2] = bus.gain2;
    gain_bus[3] = bus.gain3;
  end

  // Snapshot registers: later input changes cannot disturb the sample in flight.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (reset) begin
          in_snap[gi]   <= '0;
          gain_snap[gi] <= '0;
        end else if (capture) begin
          in_snap[gi]   <= in_bus[gi];
          gain_snap[gi] <= gain_bus[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      mute_snap <= 1'b0;
    end else if (capture) begin
      mute_snap <= bus.mute;
    end
  end

  always_comb begin
    ch_sel = 2'd0;
    case (state_reg)
      ACC0:    ch_sel = 2'd0;
      ACC1:    ch_sel = 2'd1;
      ACC2:    ch_sel = 2'd2;
      ACC3:    ch_sel = 2'd3;
      default: ch_sel = 2'd0;
    endcase
  end

  // Gain is unsigned Q1.7, zero-extended so the multiply stays signed.
  assign in_sel   = in_snap[ch_sel];
  assign gain_sel = $signed({1'b0, gain_snap[ch_sel]});
  assign prod     = in_sel * gain_sel;

  // Dropping the low 7 bits of a two's-complement value truncates toward -inf.
  assign acc_shift = acc_reg[26:7];
  assign sat_hi    = (acc_shift > 20'sd32767);
  assign sat_lo    = (acc_shift < -20'sd32768);

  always_comb begin
    sat_val = acc_shift[15:0];
    if (sat_hi) begin
      sat_val = 16'sh7FFF;
    end else if (sat_lo) begin
      sat_val = 16'sh8000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      clip_reg      <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick) begin
            acc_reg   <= '0;
            state_reg <= ACC0;
          end
        end
        ACC0, ACC1, ACC2: begin
          acc_reg   <= acc_reg + {{2{prod[24]}}, prod};
          state_reg <= state_t'(state_reg + 3'd1);
        end
        ACC3: begin
          acc_reg   <= acc_reg + {{2{prod[24]}}, prod};
          state_reg <= SAT;
        end
        SAT: begin
          out_reg       <= mute_snap ? 16'sd0 : sat_val;
          clip_reg      <= !mute_snap && (sat_hi || sat_lo);
          out_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.clip      = clip_reg;

endmodule

// File: tb/tb_tp84_sound_mixer.sv
// Directed and randomized checks of tp84_sound_mixer against an arithmetic model
// of the mix: floor((sum of in*gain)/128), clamped to 16 bits, zero when muted.
module tb_tp84_sound_mixer;

  localparam int DIV   = 32;
  localparam int BOUND = 3 * DIV;

  logic clk;
  logic reset;
  tp84_sound_mixer_if bus ();

  tp84_sound_mixer #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_in   [4];
  int cur_gain [4];
  bit cur_mute;
  int n;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint raw_mix();
    longint s = 0;
    for (int i = 0; i < 4; i++) s += longint'(cur_in[i]) * longint'(cur_gain[i]);
    // Floor division by 128.
    if (s < 0) return -((-s + 127) / 128);
    return s / 128;
  endfunction

  function automatic longint model_out();
    longint m = raw_mix();
    if (cur_mute) return 0;
    if (m > 32767) return 32767;
    if (m < -32768) return -32768;
    return m;
  endfunction

  function automatic longint model_clip();
    longint m = raw_mix();
    if (cur_mute) return 0;
    return ((m > 32767) || (m < -32768)) ? 1 : 0;
  endfunction

  task automatic apply();
    bus.in0   = 16'(cur_in[0]);
    bus.in1   = 16'(cur_in[1]);
    bus.in2   = 16'(cur_in[2]);
    bus.in3   = 16'(cur_in[3]);
    bus.gain0 = 8'(cur_gain[0]);
    bus.gain1 = 8'(cur_gain[1]);
    bus.gain2 = 8'(cur_gain[2]);
    bus.gain3 = 8'(cur_gain[3]);
    bus.mute  = cur_mute;
  endtask

  task automatic set_all(input int i0, i1, i2, i3, g0, g1, g2, g3, input bit m);
    cur_in[0] = i0; cur_in[1] = i1; cur_in[2] = i2; cur_in[3] = i3;
    cur_gain[0] = g0; cur_gain[1] = g1; cur_gain[2] = g2; cur_gain[3] = g3;
    cur_mute = m;
  endtask

  // Counts rising edges until out_valid is seen (sampled on the falling edge); -1 on timeout.
  task automatic wait_pulse(output int cnt);
    bit found = 0;
    cnt = 0;
    for (int k = 0; k < BOUND && !found; k++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (bus.out_valid === 1'b1) found = 1;
    end
    if (!found) cnt = -1;
  endtask

  // Called right after a pulse: inputs land before the next capture edge.
  task automatic do_sample(input string tag);
    apply();
    wait_pulse(n);
    chk({tag, "_per"}, n, DIV);
    chk({tag, "_out"}, $signed(bus.out), model_out());
    chk({tag, "_clip"}, bus.clip, model_clip());
  endtask

  initial begin
    set_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    reset = 1'b1;

    // 1. Reset, first-pulse latency, period, gain-0 result.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out", $signed(bus.out), 0);
      chk("rst_valid", bus.out_valid, 0);
    end
    reset = 1'b0;
    wait_pulse(n);
    chk("first_lat", n, DIV + 5);
    chk("gain0_out", $signed(bus.out), 0);
    chk("gain0_clip", bus.clip, 0);
    @(posedge clk);
    @(negedge clk);
    chk("pulse_width", bus.out_valid, 0);
    wait_pulse(n);
    chk("period", n, DIV - 1);

    // 2. Unity gains.
    set_all(1000, 2000, -500, 0, 128, 128, 128, 128, 0);
    do_sample("unity");
    chk("unity_lit", $signed(bus.out), 2500);
    set_all(1000, 2000, -500, 32767, 128, 128, 128, 0, 0);
    do_sample("gain3z");
    chk("gain3z_lit", $signed(bus.out), 2500);

    // 3. Saturation.
    set_all(32767, 32767, 32767, 32767, 255, 255, 255, 255, 0);
    do_sample("sat_pos");
    chk("sat_pos_lit", $signed(bus.out), 32767);
    chk("sat_pos_clip", bus.clip, 1);
    repeat (DIV / 2) @(negedge clk);
    chk("clip_hold", bus.clip, 1);
    set_all(-32768, -32768, -32768, -32768, 255, 255, 255, 255, 0);
    apply();
    wait_pulse(n);
    chk("sat_neg_out", $signed(bus.out), -32768);
    chk("sat_neg_clip", bus.clip, 1);

    // 4. Truncation toward -inf.
    set_all(1001, 0, 0, 0, 64, 0, 0, 0, 0);
    do_sample("trunc_pos");
    chk("trunc_pos_lit", $signed(bus.out), 500);
    set_all(-1001, 0, 0, 0, 64, 0, 0, 0, 0);
    do_sample("trunc_neg");
    chk("trunc_neg_lit", $signed(bus.out), -501);

    // 5. Snapshot: in0 changes one clock after the capture edge.
    set_all(1000, 0, 0, 0, 100, 0, 0, 0, 0);
    apply();
    repeat (DIV - 5) @(posedge clk);
    @(negedge clk);
    bus.in0 = 16'sd5000;
    wait_pulse(n);
    chk("snap_lat", n, 5);
    chk("snap_out", $signed(bus.out), 781);
    cur_in[0] = 5000;
    do_sample("snap_next");
    chk("snap_next_lit", $signed(bus.out), 3906);

    // Mute after a saturating sample: out and clip both clear, pulse still present.
    set_all(32767, 32767, 0, 0, 255, 255, 0, 0, 0);
    do_sample("pre_mute");
    cur_mute = 1;
    do_sample("mute");
    chk("mute_lit", $signed(bus.out), 0);
    cur_mute = 0;

    // 6. Reset pulsed during ACC2.
    set_all(3000, -1000, 700, 20, 128, 200, 90, 255, 0);
    do_sample("pre_rst");
    repeat (DIV - 3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out", $signed(bus.out), 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    wait_pulse(n);
    chk("mid_rst_lat", n, DIV + 5);
    chk("mid_rst_sum", $signed(bus.out), model_out());
    chk("mid_rst_clip", bus.clip, model_clip());

    // Randomized samples, alternating small and full-scale inputs.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) begin
        cur_in[i]   = (t % 2 == 0) ? int'($urandom_range(0, 8000)) - 4000
                                   : int'($urandom_range(0, 65535)) - 32768;
        cur_gain[i] = int'($urandom_range(0, 255));
      end
      cur_mute = ($urandom_range(0, 5) == 0);
      do_sample("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
